// File: rtl/packet_parity_accum.sv
// Accumulates the XOR parity and beat count of a valid/ready packet stream and
// emits one registered result per packet, with a one-entry output holding stage.
module packet_parity_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int ODD   = 0
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_overflow
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready.
  // A result transfers on a rising edge where out_valid && out_ready. in_ready
  // is combinational so a consumed result can be replaced on the same edge.

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic             ODD_BIT = (ODD != 0);

  logic             acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             beat_par;
  logic             cnt_full;
  logic [CNT_W-1:0] cnt_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign beat_par = ^in_data;
  assign cnt_full = (cnt == CNT_MAX);
  assign cnt_next = cnt_full ? cnt : cnt + CNT_W'(1);

  // Running state of the packet in progress; cleared on its last beat.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc <= 1'b0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        acc <= 1'b0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= acc ^ beat_par;
        cnt <= cnt_next;
        ovf <= ovf | cnt_full;
      end
    end
  end

  // Result register: a new result overwrites one being consumed on the same edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid    <= 1'b0;
      out_parity   <= 1'b0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
    end else if (accept && in_last) begin
      out_valid    <= 1'b1;
      out_parity   <= acc ^ beat_par ^ ODD_BIT;
      out_beats    <= cnt_next;
      out_overflow <= ovf | cnt_full;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_parity_accum.sv
// Three instances (default, ODD=1, CNT_W=2) share one stimulus stream; a packet
// level reference model feeds a scoreboard queue that a negedge monitor drains.
module tb_packet_parity_accum;

  logic       clk;
  logic       aresetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       ir0, ir1, ir2;
  logic       ov0, ov1, ov2;
  logic       op0, op1, op2;
  logic [7:0] ob0, ob1;
  logic [1:0] ob2;
  logic       of0, of1, of2;

  int total = 0;
  int bad   = 0;

  // Expected entry: {inst2, inst1, inst0}, each {overflow, beats[7:0], parity}.
  logic [29:0] exp_q[$];
  logic [7:0]  pkt_q[$];
  logic        mv;

  packet_parity_accum #(.WIDTH(8), .CNT_W(8), .ODD(0)) u0 (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
    .out_parity(op0), .out_beats(ob0), .out_overflow(of0));

  packet_parity_accum #(.WIDTH(8), .CNT_W(8), .ODD(1)) u1 (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
    .out_parity(op1), .out_beats(ob1), .out_overflow(of1));

  packet_parity_accum #(.WIDTH(8), .CNT_W(2), .ODD(0)) u2 (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
    .out_parity(op2), .out_beats(ob2), .out_overflow(of2));

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] act_word();
    return {of2, 6'b0, ob2, op2, of1, ob1, op1, of0, ob0, op0};
  endfunction

  // ---------------- reference model ----------------
  // Works on whole packets: the beats are collected, and on the last beat the
  // result follows from the total number of ones and the total beat count.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_q.delete();
      exp_q.delete();
      mv = 1'b0;
    end else begin
      logic exp_ready;
      exp_ready = !mv || out_ready;
      if (in_valid && exp_ready) begin
        pkt_q.push_back(in_data);
        if (in_last) begin
          int ones;
          int n;
          logic par;
          logic [9:0] e0, e1, e2;
          ones = 0;
          foreach (pkt_q[i]) ones += $countones(pkt_q[i]);
          n   = pkt_q.size();
          par = ones[0];
          e0  = {(n > 255), (n > 255) ? 8'd255 : 8'(n), par};
          e1  = {(n > 255), (n > 255) ? 8'd255 : 8'(n), ~par};
          e2  = {(n > 3), 6'b0, (n > 3) ? 2'd3 : 2'(n), par};
          exp_q.push_back({e2, e1, e0});
          pkt_q.delete();
          mv = 1'b1;
        end else if (out_ready) begin
          mv = 1'b0;
        end
      end else if (out_ready) begin
        mv = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        stalled = 1'b0;
  logic [29:0] held;

  always @(negedge clk) begin
    if (aresetn) begin
      chk("out_valid0", {31'b0, ov0}, {31'b0, mv});
      chk("out_valid1", {31'b0, ov1}, {31'b0, mv});
      chk("out_valid2", {31'b0, ov2}, {31'b0, mv});
      chk("in_ready", {29'b0, ir2, ir1, ir0}, {29'b0, {3{!mv || out_ready}}});
      if (ov0 && stalled)
        chk("held_stable", {2'b0, act_word()}, {2'b0, held});
      stalled = ov0 && !out_ready;
      held    = act_word();
      if (ov0 && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("result_unexpected", 32'd1, 32'd0);
        end else begin
          logic [29:0] e;
          e = exp_q.pop_front();
          chk("result", {2'b0, act_word()}, {2'b0, e});
        end
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #2 aresetn = 1'b0;
    #1;
    chk("rst_valid", {29'b0, ov2, ov1, ov0}, 32'd0);
    chk("rst_data0", {22'b0, of0, ob0, op0}, 32'd0);
    chk("rst_data2", {28'b0, of2, ob2, op2}, 32'd0);
    chk("rst_ready", {29'b0, ir2, ir1, ir0}, 32'd7);
    #2 aresetn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    aresetn   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", {29'b0, ov2, ov1, ov0}, 32'd0);
    chk("init_data0", {22'b0, of0, ob0, op0}, 32'd0);
    chk("init_data1", {22'b0, of1, ob1, op1}, 32'd0);
    chk("init_ready", {29'b0, ir2, ir1, ir0}, 32'd7);
    aresetn = 1'b1;

    // single beat 0x07
    cyc(1, 8'h07, 1, 1);
    chk("single07", {22'b0, ov0, of0, ob0, op0}, {22'b0, 1'b1, 1'b0, 8'd1, 1'b1});
    cyc(0, 8'h00, 0, 1);
    chk("single07_clear", {31'b0, ov0}, 32'd0);

    // three-beat packet 01,03,FF
    cyc(1, 8'h01, 0, 1);
    cyc(1, 8'h03, 0, 1);
    cyc(1, 8'hFF, 1, 1);
    chk("three_beat", {23'b0, of0, ob0, op0}, {23'b0, 1'b0, 8'd3, 1'b1});

    // odd parity of an all-zero beat
    cyc(1, 8'h00, 1, 1);
    chk("odd_zero", {22'b0, op1, ob1, op0}, {22'b0, 1'b1, 8'd1, 1'b0});

    // held result with pending beats, then replace without a bubble
    cyc(1, 8'h55, 1, 0);
    repeat (3) begin
      cyc(1, 8'h12, 0, 0);
      chk("stall_ready", {31'b0, ir0}, 32'd0);
      chk("stall_hold", {22'b0, ov0, of0, ob0, op0}, {22'b0, 1'b1, 1'b0, 8'd1, 1'b0});
    end
    cyc(1, 8'h80, 1, 1);
    chk("replace", {22'b0, ov0, of0, ob0, op0}, {22'b0, 1'b1, 1'b0, 8'd1, 1'b1});

    // five beats saturate the 2-bit counter
    repeat (4) cyc(1, 8'h00, 0, 1);
    cyc(1, 8'h00, 1, 1);
    chk("sat_cnt2", {28'b0, of2, ob2, op2}, {28'b0, 1'b1, 2'd3, 1'b0});
    chk("sat_cnt8", {23'b0, of0, ob0, op0}, {23'b0, 1'b0, 8'd5, 1'b0});
    cyc(1, 8'h03, 1, 1);
    chk("sat_next", {28'b0, of2, ob2, op2}, {28'b0, 1'b0, 2'd1, 1'b0});

    // 259-beat packet saturates the 8-bit counter
    repeat (258) cyc(1, 8'($urandom_range(0, 255)), 0, 1);
    cyc(1, 8'h01, 1, 1);
    chk("sat_cnt8_long", {23'b0, of0, ob0}, {23'b0, 1'b1, 8'd255});

    // reset clears a pending result immediately
    cyc(1, 8'h07, 1, 0);
    reset_pulse();

    // reset discards a partial packet
    cyc(1, 8'h01, 0, 1);
    cyc(1, 8'h01, 0, 1);
    reset_pulse();
    cyc(1, 8'h00, 1, 1);
    chk("post_reset", {22'b0, ov0, of0, ob0, op0}, {22'b0, 1'b1, 1'b0, 8'd1, 1'b0});

    // randomized traffic
    repeat (600) begin
      cyc(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6));
    end

    // drain
    repeat (4) cyc(0, 8'h00, 0, 1);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
